// File: rtl/branch_predict_ctrl_pkg.sv
// Shared decode constants and helpers for the branch predictor / EX resolver.
// Encodings match the legacy jump decoder so the existing PC mux is unchanged.
package branch_predict_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef enum logic [1:0] {
    JOP_NONE = 2'b00,
    JOP_BR   = 2'b01,
    JOP_JR   = 2'b10,
    JOP_J    = 2'b11
  } jop_e;

  function automatic logic is_ctl(input logic [5:0] opcode, input logic [5:0] funct);
    logic r;
    r = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_J) || (opcode == OP_JAL) ||
        ((opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR)));
    return r;
  endfunction

  function automatic jop_e decode_jop(input logic [5:0] opcode, input logic [5:0] funct,
                                     input logic zero);
    jop_e j;
    j = JOP_NONE;
    if ((opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR))) j = JOP_JR;
    else if ((opcode == OP_J) || (opcode == OP_JAL))                       j = JOP_J;
    else if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero)) j = JOP_BR;
    return j;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_sat_ctr2.sv
// 2-bit saturating counter step: count up on taken, down on not-taken.
module sat_ctr2 (
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i && (ctr_i != 2'b11))      ctr_o = ctr_i + 2'b01;
    else if (!taken_i && (ctr_i != 2'b00)) ctr_o = ctr_i - 2'b01;
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB + 2-bit counter predictor with EX-stage resolution,
// registered mispredict flush/redirect and saturating statistics.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int         PC_W     = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [5:0]        ex_opcode,
  input  logic [5:0]        ex_funct,
  input  logic              ex_zero,
  input  logic [PC_W-1:0]   ex_br_target,
  input  logic [PC_W-1:0]   ex_j_target,
  input  logic [PC_W-1:0]   ex_jr_target,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  output logic [1:0]        jump_op,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];

  logic              flush_q, flush_d;
  logic [PC_W-1:0]   redirect_q, redirect_d;
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // Fetch: asynchronous read of the pre-update table, no bypass from EX.
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx      = if_pc[IDX_W+1:2];
  assign if_tag      = if_pc[PC_W-1:IDX_W+2];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = if_hit ? tgt_q[if_idx] : if_pc + PC_W'(4);

  // ex_valid qualifies every EX input for one cycle; there is no backpressure,
  // the resolution is consumed on the clock edge at which ex_valid is high.
  jop_e             jop;
  logic             ex_ctl, ex_upd, actual_taken, mispredict, ex_hit;
  logic [PC_W-1:0]  next_pc;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic [1:0]       ctr_step, alloc_ctr;

  assign jop          = decode_jop(ex_opcode, ex_funct, ex_zero);
  assign jump_op      = jop;
  assign ex_ctl       = is_ctl(ex_opcode, ex_funct);
  assign ex_upd       = ex_valid && ex_ctl;
  assign actual_taken = (jop != JOP_NONE);
  assign ex_idx       = ex_pc[IDX_W+1:2];
  assign ex_tag       = ex_pc[PC_W-1:IDX_W+2];
  assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign alloc_ctr    = (jop == JOP_BR) ? 2'b10 : 2'b11;

  // Not-taken resolves to the fall-through, so next_pc doubles as the redirect.
  always_comb begin
    next_pc = ex_pc + PC_W'(4);
    case (jop)
      JOP_BR:  next_pc = ex_br_target;
      JOP_J:   next_pc = ex_j_target;
      JOP_JR:  next_pc = ex_jr_target;
      default: next_pc = ex_pc + PC_W'(4);
    endcase
  end

  assign mispredict = ex_upd && ((actual_taken != ex_pred_taken) ||
                                 (actual_taken && (ex_pred_target != next_pc)));

  sat_ctr2 u_sat_ctr2 (
    .ctr_i   (ctr_q[ex_idx]),
    .taken_i (actual_taken),
    .ctr_o   (ctr_step)
  );

  always_comb begin
    flush_d       = mispredict;
    redirect_d    = mispredict ? next_pc : redirect_q;
    br_cnt_d      = (ex_upd && (br_cnt_q != '1)) ? br_cnt_q + STAT_W'(1) : br_cnt_q;
    mispred_cnt_d = (mispredict && (mispred_cnt_q != '1)) ? mispred_cnt_q + STAT_W'(1)
                                                          : mispred_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (ex_upd) begin
        if (ex_hit) begin
          ctr_q[ex_idx] <= ctr_step;
        end else if (actual_taken) begin
          valid_q[ex_idx] <= 1'b1;
          ctr_q[ex_idx]   <= alloc_ctr;
        end
      end
    end
  end

  // Tag/target payload is only meaningful behind valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rst && ex_upd && actual_taken) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= next_pc;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: prediction, resolution, aliasing,
// mid-run reset and statistics saturation with hand-computed expectations.
module tb_branch_predict_ctrl;
  import branch_predict_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;
  logic        ex_zero;
  logic [31:0] ex_br_target;
  logic [31:0] ex_j_target;
  logic [31:0] ex_jr_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [1:0]  jump_op;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] br_cnt;
  logic [15:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] JUNK_A = 32'hDEAD_0000;
  localparam logic [31:0] JUNK_B = 32'hBEEF_0000;

  branch_predict_ctrl #(
    .PC_W(32), .ENTRIES(16), .CTR_INIT(2'b01), .STAT_W(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_opcode      (ex_opcode),
    .ex_funct       (ex_funct),
    .ex_zero        (ex_zero),
    .ex_br_target   (ex_br_target),
    .ex_j_target    (ex_j_target),
    .ex_jr_target   (ex_jr_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .jump_op        (jump_op),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .br_cnt         (br_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic [31:0] pc, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic [31:0] brt,
                        input logic [31:0] jt, input logic [31:0] jrt, input logic pt,
                        input logic [31:0] ptgt);
    ex_valid       = v;
    ex_pc          = pc;
    ex_opcode      = op;
    ex_funct       = fn;
    ex_zero        = z;
    ex_br_target   = brt;
    ex_j_target    = jt;
    ex_jr_target   = jrt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic ex_idle();
    ex_valid = 1'b0;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] pc, input logic exp_taken,
                           input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    chk({tag, ".target"}, pred_target, exp_tgt);
  endtask

  task automatic res_chk(input string tag, input logic exp_flush, input logic [31:0] exp_red,
                         input logic [15:0] exp_br, input logic [15:0] exp_mis);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, exp_flush});
    if (exp_flush) chk({tag, ".redirect"}, redirect_pc, exp_red);
    chk({tag, ".br_cnt"}, {16'd0, br_cnt}, {16'd0, exp_br});
    chk({tag, ".mispred_cnt"}, {16'd0, mispred_cnt}, {16'd0, exp_mis});
  endtask

  initial begin
    rst = 1'b0;
    if_pc = 32'h40;
    ex_set(1'b0, 32'h0, OP_RTYPE, 6'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) tick();
    rst = 1'b1;

    // reset state
    chk("rst.flush", {31'd0, flush}, 32'd0);
    chk("rst.redirect", redirect_pc, 32'd0);
    res_chk("rst", 1'b0, 32'h0, 16'd0, 16'd0);
    fetch_chk("rst.f40", 32'h40, 1'b0, 32'h44);

    // first beq taken: miss -> allocate weakly taken, mispredict
    ex_set(1'b1, 32'h40, OP_BEQ, 6'h0, 1'b1, 32'h80, JUNK_A, JUNK_B, 1'b0, 32'h44);
    #1;
    chk("beq.jop", {30'd0, jump_op}, 32'd1);
    fetch_chk("beq.nobypass", 32'h40, 1'b0, 32'h44);
    tick();
    res_chk("beq1", 1'b1, 32'h80, 16'd1, 16'd1);
    ex_idle();
    tick();
    chk("beq1.flush_drop", {31'd0, flush}, 32'd0);
    fetch_chk("beq1.f40", 32'h40, 1'b1, 32'h80);

    // three more correctly predicted taken resolutions
    for (int i = 0; i < 3; i++) begin
      ex_set(1'b1, 32'h40, OP_BEQ, 6'h0, 1'b1, 32'h80, JUNK_A, JUNK_B, 1'b1, 32'h80);
      tick();
      chk("beq_hit.flush", {31'd0, flush}, 32'd0);
    end
    res_chk("beq_x4", 1'b0, 32'h0, 16'd4, 16'd1);

    // not taken while predicted taken: ctr 11 -> 10
    ex_set(1'b1, 32'h40, OP_BEQ, 6'h0, 1'b0, 32'h80, JUNK_A, JUNK_B, 1'b1, 32'h80);
    #1;
    chk("beq_nt.jop", {30'd0, jump_op}, 32'd0);
    tick();
    res_chk("beq_nt1", 1'b1, 32'h44, 16'd5, 16'd2);
    ex_idle();
    fetch_chk("beq_nt1.f40", 32'h40, 1'b1, 32'h80);
    tick();
    // second not-taken: ctr 10 -> 01, entry still hits
    ex_set(1'b1, 32'h40, OP_BEQ, 6'h0, 1'b0, 32'h80, JUNK_A, JUNK_B, 1'b1, 32'h80);
    tick();
    res_chk("beq_nt2", 1'b1, 32'h44, 16'd6, 16'd3);
    ex_idle();
    fetch_chk("beq_nt2.f40", 32'h40, 1'b0, 32'h80);
    tick();

    // jr at 0x100 (aliases idx 0): first correct, then target change
    ex_set(1'b1, 32'h100, OP_RTYPE, FN_JR, 1'b0, JUNK_A, JUNK_B, 32'h200, 1'b1, 32'h200);
    #1;
    chk("jr.jop", {30'd0, jump_op}, 32'd2);
    tick();
    res_chk("jr1", 1'b0, 32'h0, 16'd7, 16'd3);
    fetch_chk("jr1.f100", 32'h100, 1'b1, 32'h200);
    ex_set(1'b1, 32'h100, OP_RTYPE, FN_JR, 1'b0, JUNK_A, JUNK_B, 32'h300, 1'b1, 32'h200);
    tick();
    res_chk("jr2", 1'b1, 32'h300, 16'd8, 16'd4);
    ex_idle();
    fetch_chk("jr2.f100", 32'h100, 1'b1, 32'h300);
    fetch_chk("jr2.f40", 32'h40, 1'b0, 32'h44);
    tick();

    // j, jalr, bne, and a non-control instruction
    ex_set(1'b1, 32'h48, OP_J, 6'h0, 1'b0, JUNK_A, 32'h1000, JUNK_B, 1'b0, 32'h4C);
    #1;
    chk("j.jop", {30'd0, jump_op}, 32'd3);
    tick();
    res_chk("j", 1'b1, 32'h1000, 16'd9, 16'd5);
    ex_set(1'b1, 32'h10C, OP_RTYPE, FN_JALR, 1'b1, JUNK_A, JUNK_B, 32'h400, 1'b0, 32'h110);
    #1;
    chk("jalr.jop", {30'd0, jump_op}, 32'd2);
    tick();
    res_chk("jalr", 1'b1, 32'h400, 16'd10, 16'd6);
    ex_set(1'b1, 32'h84, OP_BNE, 6'h0, 1'b0, 32'h50, JUNK_A, JUNK_B, 1'b0, 32'h88);
    #1;
    chk("bne.jop", {30'd0, jump_op}, 32'd1);
    tick();
    res_chk("bne", 1'b1, 32'h50, 16'd11, 16'd7);
    ex_set(1'b1, 32'h90, OP_RTYPE, 6'h20, 1'b1, JUNK_A, JUNK_B, 32'h1234, 1'b1, 32'h1234);
    #1;
    chk("add.jop", {30'd0, jump_op}, 32'd0);
    tick();
    res_chk("add", 1'b0, 32'h0, 16'd11, 16'd7);
    ex_set(1'b0, 32'h84, OP_BNE, 6'h0, 1'b1, 32'h50, JUNK_A, JUNK_B, 1'b0, 32'h88);
    #1;
    chk("bne_nt.jop", {30'd0, jump_op}, 32'd0);
    fetch_chk("f48", 32'h48, 1'b1, 32'h1000);
    fetch_chk("f84", 32'h84, 1'b1, 32'h50);
    fetch_chk("f10c", 32'h10C, 1'b1, 32'h400);
    tick();

    // aliasing on idx 0: 0x40 re-allocates, then 0x440 evicts it
    ex_set(1'b1, 32'h40, OP_BEQ, 6'h0, 1'b1, 32'h80, JUNK_A, JUNK_B, 1'b0, 32'h44);
    tick();
    res_chk("alias40", 1'b1, 32'h80, 16'd12, 16'd8);
    ex_idle();
    fetch_chk("alias40.f40", 32'h40, 1'b1, 32'h80);
    fetch_chk("alias40.f100", 32'h100, 1'b0, 32'h104);
    ex_set(1'b1, 32'h440, OP_BEQ, 6'h0, 1'b1, 32'h500, JUNK_A, JUNK_B, 1'b0, 32'h444);
    fetch_chk("alias440.same_cycle", 32'h440, 1'b0, 32'h444);
    tick();
    res_chk("alias440", 1'b1, 32'h500, 16'd13, 16'd9);
    ex_idle();
    fetch_chk("alias440.f40", 32'h40, 1'b0, 32'h44);
    fetch_chk("alias440.f440", 32'h440, 1'b1, 32'h500);

    // reset while a flush is pending and EX is still mispredicting
    ex_set(1'b1, 32'h40, OP_BEQ, 6'h0, 1'b0, 32'h80, JUNK_A, JUNK_B, 1'b1, 32'h80);
    tick();
    res_chk("pre_rst", 1'b1, 32'h44, 16'd14, 16'd10);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ex_idle();
    chk("mid_rst.redirect", redirect_pc, 32'd0);
    res_chk("mid_rst", 1'b0, 32'h0, 16'd0, 16'd0);
    fetch_chk("mid_rst.f440", 32'h440, 1'b0, 32'h444);
    fetch_chk("mid_rst.f48", 32'h48, 1'b0, 32'h4C);
    fetch_chk("mid_rst.f84", 32'h84, 1'b0, 32'h88);

    // statistics saturation under a continuous forced mispredict
    ex_set(1'b1, 32'h40, OP_BEQ, 6'h0, 1'b0, 32'h80, JUNK_A, JUNK_B, 1'b1, 32'h44);
    repeat (65534) @(posedge clk);
    #1;
    res_chk("sat_m1", 1'b1, 32'h44, 16'hFFFE, 16'hFFFE);
    tick();
    res_chk("sat0", 1'b1, 32'h44, 16'hFFFF, 16'hFFFF);
    tick();
    res_chk("sat1", 1'b1, 32'h44, 16'hFFFF, 16'hFFFF);
    ex_idle();
    tick();
    chk("sat.flush_drop", {31'd0, flush}, 32'd0);
    chk("sat.hold", {16'd0, mispred_cnt}, 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
